// File: rtl/mymy_wide.sv
// mymy_wide: WIDTH-bit 2901-style ALU with register file, Q register and a one-cycle result stage.
// Define MYMY_WIDE_ROTATE_EN to make the RAM/Q shifts rotate instead of taking the shift-in ports.
module mymy_wide #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             cp,
  input  logic             rstBar,
  input  logic             instrValid,
  input  logic [8:0]       I,
  input  logic [AW-1:0]    addrA,
  input  logic [AW-1:0]    addrB,
  input  logic [WIDTH-1:0] D,
  input  logic             cN,
  input  logic             ramInLsb,
  input  logic             ramInMsb,
  input  logic             qInLsb,
  input  logic             qInMsb,
  output logic             ramOutLsb,
  output logic             ramOutMsb,
  output logic             qOutLsb,
  output logic             qOutMsb,
  output logic [WIDTH-1:0] Y,
  output logic             yValid,
  output logic             cOut,
  output logic             ovf,
  output logic             fZero,
  output logic             fSign
);

  localparam logic [2:0] DST_QREG  = 3'd0;
  localparam logic [2:0] DST_NOP   = 3'd1;
  localparam logic [2:0] DST_RAMA  = 3'd2;
  localparam logic [2:0] DST_RAMF  = 3'd3;
  localparam logic [2:0] DST_RAMQD = 3'd4;
  localparam logic [2:0] DST_RAMD  = 3'd5;
  localparam logic [2:0] DST_RAMQU = 3'd6;
  localparam logic [2:0] DST_RAMU  = 3'd7;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] q_reg;

  logic [2:0]       src;
  logic [2:0]       fn;
  logic [2:0]       dst;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] s_op;
  logic [WIDTH-1:0] x_op;
  logic [WIDTH-1:0] y_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] f_val;
  logic             arith;
  logic             c_next;
  logic             ovf_next;

  logic             ram_dn_in;
  logic             ram_up_in;
  logic             q_dn_in;
  logic             q_up_in;
  logic             ram_we;
  logic             q_we;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] y_next;

  assign src = I[2:0];
  assign fn  = I[5:3];
  assign dst = I[8:6];

  // Reads come straight from the flops, so a same-address write returns the old value.
  assign a_val = regs[addrA];
  assign b_val = regs[addrB];

  always_comb begin
    r_op = '0;
    s_op = '0;
    case (src)
      3'd0: begin r_op = a_val; s_op = q_reg; end
      3'd1: begin r_op = a_val; s_op = b_val; end
      3'd2: begin r_op = '0;    s_op = q_reg; end
      3'd3: begin r_op = '0;    s_op = b_val; end
      3'd4: begin r_op = '0;    s_op = a_val; end
      3'd5: begin r_op = D;     s_op = a_val; end
      3'd6: begin r_op = D;     s_op = q_reg; end
      default: begin r_op = D;  s_op = '0;    end
    endcase
  end

  // All three arithmetic functions reduce to one adder with a per-function operand swap/invert.
  always_comb begin
    x_op = r_op;
    y_op = s_op;
    case (fn)
      3'd1: begin x_op = s_op; y_op = ~r_op; end
      3'd2: y_op = ~s_op;
      default: ;
    endcase
  end

  assign sum   = {1'b0, x_op} + {1'b0, y_op} + {{WIDTH{1'b0}}, cN};
  assign arith = (fn <= 3'd2);

  always_comb begin
    f_val = sum[WIDTH-1:0];
    case (fn)
      3'd3: f_val = r_op | s_op;
      3'd4: f_val = r_op & s_op;
      3'd5: f_val = ~r_op & s_op;
      3'd6: f_val = r_op ^ s_op;
      3'd7: f_val = ~(r_op ^ s_op);
      default: ;
    endcase
  end

  // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
  assign c_next   = arith & sum[WIDTH];
  assign ovf_next = arith & (sum[WIDTH] ^ sum[WIDTH-1] ^ x_op[WIDTH-1] ^ y_op[WIDTH-1]);

`ifdef MYMY_WIDE_ROTATE_EN
  assign ram_dn_in = f_val[0];
  assign ram_up_in = f_val[WIDTH-1];
  assign q_dn_in   = q_reg[0];
  assign q_up_in   = q_reg[WIDTH-1];
`else
  assign ram_dn_in = ramInMsb;
  assign ram_up_in = ramInLsb;
  assign q_dn_in   = qInMsb;
  assign q_up_in   = qInLsb;
`endif

  always_comb begin
    ram_we    = 1'b1;
    q_we      = 1'b0;
    ram_wdata = f_val;
    q_next    = q_reg;
    y_next    = f_val;
    case (dst)
      DST_QREG: begin
        ram_we = 1'b0;
        q_we   = 1'b1;
        q_next = f_val;
      end
      DST_NOP:  ram_we = 1'b0;
      DST_RAMA: y_next = a_val;
      DST_RAMF: ;
      DST_RAMQD: begin
        ram_wdata = {ram_dn_in, f_val[WIDTH-1:1]};
        q_we      = 1'b1;
        q_next    = {q_dn_in, q_reg[WIDTH-1:1]};
      end
      DST_RAMD: ram_wdata = {ram_dn_in, f_val[WIDTH-1:1]};
      DST_RAMQU: begin
        ram_wdata = {f_val[WIDTH-2:0], ram_up_in};
        q_we      = 1'b1;
        q_next    = {q_reg[WIDTH-2:0], q_up_in};
      end
      DST_RAMU: ram_wdata = {f_val[WIDTH-2:0], ram_up_in};
      default: ;
    endcase
  end

  // Shift-out linkage is purely a function of the destination code, independent of instrValid.
  assign ramOutLsb = ((dst == DST_RAMQD) || (dst == DST_RAMD)) & f_val[0];
  assign ramOutMsb = ((dst == DST_RAMQU) || (dst == DST_RAMU)) & f_val[WIDTH-1];
  assign qOutLsb   = (dst == DST_RAMQD) & q_reg[0];
  assign qOutMsb   = (dst == DST_RAMQU) & q_reg[WIDTH-1];

  always_ff @(posedge cp or negedge rstBar) begin
    if (!rstBar) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      q_reg  <= '0;
      Y      <= '0;
      yValid <= 1'b0;
      cOut   <= 1'b0;
      ovf    <= 1'b0;
      fZero  <= 1'b0;
      fSign  <= 1'b0;
    end else begin
      yValid <= instrValid;
      if (instrValid) begin
        if (ram_we) begin
          regs[addrB] <= ram_wdata;
        end
        if (q_we) begin
          q_reg <= q_next;
        end
        Y     <= y_next;
        cOut  <= c_next;
        ovf   <= ovf_next;
        fZero <= (f_val == '0);
        fSign <= f_val[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_mymy_wide.sv
// Testbench for mymy_wide: vector table plus hand sequences, results checked through a queue scoreboard.
// Shift expectations follow MYMY_WIDE_ROTATE_EN when it is defined.
module tb_mymy_wide;

  localparam logic [2:0] QREG = 3'd0, NOP = 3'd1, RAMA = 3'd2, RAMF = 3'd3;
  localparam logic [2:0] RAMQD = 3'd4, RAMD = 3'd5, RAMQU = 3'd6, RAMU = 3'd7;
  localparam logic [2:0] ADD = 3'd0, SUBR = 3'd1, SUBS = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] AND_ = 3'd4, NOTRS = 3'd5, EXOR = 3'd6, EXNOR = 3'd7;
  localparam logic [2:0] AQ = 3'd0, AB = 3'd1, ZQ = 3'd2, ZB = 3'd3;
  localparam logic [2:0] ZA = 3'd4, DA = 3'd5, DQ = 3'd6, DZ = 3'd7;

`ifdef MYMY_WIDE_ROTATE_EN
  localparam logic [15:0] Q_D = 16'hC000, Q_U = 16'h8001, R7 = 16'h8001, AQ_SUM = 16'h8004;
  localparam logic QD_S = 1'b1, QU_QM = 1'b1, R7_S = 1'b1;
`else
  localparam logic [15:0] Q_D = 16'h4000, Q_U = 16'h8000, R7 = 16'h0001, AQ_SUM = 16'h8003;
  localparam logic QD_S = 1'b0, QU_QM = 1'b0, R7_S = 1'b0;
`endif

  logic        cp = 1'b0;
  logic        rstBar = 1'b1;
  logic        instrValid = 1'b0;
  logic [8:0]  I = '0;
  logic [3:0]  addrA = '0, addrB = '0;
  logic [15:0] D = '0;
  logic        cN = 1'b0, ramInLsb = 1'b0, ramInMsb = 1'b0, qInLsb = 1'b0, qInMsb = 1'b0;
  logic        ramOutLsb, ramOutMsb, qOutLsb, qOutMsb;
  logic [15:0] Y;
  logic        yValid, cOut, ovf, fZero, fSign;

  mymy_wide #(.WIDTH(16), .NREGS(16)) dut (
    .cp(cp), .rstBar(rstBar), .instrValid(instrValid), .I(I),
    .addrA(addrA), .addrB(addrB), .D(D), .cN(cN),
    .ramInLsb(ramInLsb), .ramInMsb(ramInMsb), .qInLsb(qInLsb), .qInMsb(qInMsb),
    .ramOutLsb(ramOutLsb), .ramOutMsb(ramOutMsb), .qOutLsb(qOutLsb), .qOutMsb(qOutMsb),
    .Y(Y), .yValid(yValid), .cOut(cOut), .ovf(ovf), .fZero(fZero), .fSign(fSign)
  );

  always #5 cp = ~cp;

  // shin = {ramInMsb, ramInLsb, qInMsb, qInLsb}; fl = {cOut, ovf, fZero, fSign};
  // so = {ramOutLsb, ramOutMsb, qOutLsb, qOutMsb}
  typedef struct {
    logic [8:0]  i;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] d;
    logic        cn;
    logic [3:0]  shin;
    logic [15:0] y;
    logic [3:0]  fl;
    logic [3:0]  so;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [8:0] ins(input logic [2:0] dst, input logic [2:0] fn, input logic [2:0] src);
    return {dst, fn, src};
  endfunction

  function automatic vec_t mk(input logic [8:0] i, input int a, input int b, input logic [15:0] d,
                              input logic cn, input logic [3:0] shin, input logic [15:0] y,
                              input logic [3:0] fl, input logic [3:0] so);
    vec_t v;
    v.i = i; v.a = 4'(a); v.b = 4'(b); v.d = d; v.cn = cn;
    v.shin = shin; v.y = y; v.fl = fl; v.so = so;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".yValid"}, {31'd0, yValid}, 32'd1);
      chk({tag, ".Y"}, {16'd0, Y}, {16'd0, e.y});
      chk({tag, ".flags"}, {28'd0, cOut, ovf, fZero, fSign}, {28'd0, e.fl});
    end else begin
      chk({tag, ".yValid_idle"}, {31'd0, yValid}, 32'd0);
    end
  endtask

  // Drive after a falling edge, check shift-outs combinationally, check the result one edge later.
  task automatic drive(input vec_t v, input logic valid, input string tag);
    exp_t e;
    instrValid = valid;
    I = v.i; addrA = v.a; addrB = v.b; D = v.d; cN = v.cn;
    {ramInMsb, ramInLsb, qInMsb, qInLsb} = v.shin;
    #1;
    chk({tag, ".shout"}, {28'd0, ramOutLsb, ramOutMsb, qOutLsb, qOutMsb}, {28'd0, v.so});
    if (valid) begin
      e.y = v.y;
      e.fl = v.fl;
      sb.push_back(e);
    end
    @(negedge cp);
    check_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rstBar = 1'b0;
    repeat (2) @(negedge cp);
    chk("reset.Y", {16'd0, Y}, 32'd0);
    chk("reset.yValid", {31'd0, yValid}, 32'd0);
    chk("reset.flags", {28'd0, cOut, ovf, fZero, fSign}, 32'd0);
    rstBar = 1'b1;

    tbl.push_back(mk(ins(RAMF, OR_, DZ), 0, 1, 16'h7FFF, 0, 4'b0000, 16'h7FFF, 4'b0000, 4'b0000));
    tbl.push_back(mk(ins(RAMF, ADD, AB), 1, 1, 16'h0000, 1, 4'b0000, 16'hFFFF, 4'b0101, 4'b0000));
    tbl.push_back(mk(ins(NOP, OR_, ZA), 1, 0, 16'h0000, 0, 4'b0000, 16'hFFFF, 4'b0001, 4'b0000));
    tbl.push_back(mk(ins(RAMF, OR_, DZ), 0, 2, 16'h0005, 0, 4'b0000, 16'h0005, 4'b0000, 4'b0000));
    tbl.push_back(mk(ins(NOP, SUBS, DA), 2, 0, 16'h0005, 1, 4'b0000, 16'h0000, 4'b1010, 4'b0000));
    tbl.push_back(mk(ins(NOP, SUBR, DA), 2, 0, 16'h0003, 1, 4'b0000, 16'h0002, 4'b1000, 4'b0000));
    tbl.push_back(mk(ins(QREG, OR_, DZ), 0, 0, 16'h8001, 0, 4'b0000, 16'h8001, 4'b0001, 4'b0000));
    tbl.push_back(mk(ins(RAMF, OR_, DZ), 0, 3, 16'h8001, 0, 4'b0000, 16'h8001, 4'b0001, 4'b0000));
    tbl.push_back(mk(ins(RAMQD, OR_, ZA), 3, 3, 16'h0000, 0, 4'b1000, 16'h8001, 4'b0001, 4'b1010));
    tbl.push_back(mk(ins(NOP, OR_, ZA), 3, 0, 16'h0000, 0, 4'b0000, 16'hC000, 4'b0001, 4'b0000));
    tbl.push_back(mk(ins(NOP, OR_, ZQ), 0, 0, 16'h0000, 0, 4'b0000, Q_D, {3'b000, QD_S}, 4'b0000));
    tbl.push_back(mk(ins(RAMA, AND_, DA), 3, 5, 16'h3000, 0, 4'b0000, 16'hC000, 4'b0010, 4'b0000));
    tbl.push_back(mk(ins(NOP, OR_, ZB), 0, 5, 16'h0000, 0, 4'b0000, 16'h0000, 4'b0010, 4'b0000));
    tbl.push_back(mk(ins(NOP, EXOR, DA), 3, 0, 16'hFFFF, 0, 4'b0000, 16'h3FFF, 4'b0000, 4'b0000));
    tbl.push_back(mk(ins(NOP, EXNOR, DA), 5, 0, 16'h1234, 0, 4'b0000, 16'hEDCB, 4'b0001, 4'b0000));
    tbl.push_back(mk(ins(NOP, NOTRS, DA), 3, 0, 16'h4000, 0, 4'b0000, 16'h8000, 4'b0001, 4'b0000));
    tbl.push_back(mk(ins(RAMQU, OR_, DZ), 0, 6, 16'h8001, 0, 4'b0100, 16'h8001, 4'b0001, {3'b010, QU_QM}));
    tbl.push_back(mk(ins(NOP, OR_, ZB), 0, 6, 16'h0000, 0, 4'b0000, 16'h0003, 4'b0000, 4'b0000));
    tbl.push_back(mk(ins(NOP, OR_, ZQ), 0, 0, 16'h0000, 0, 4'b0000, Q_U, 4'b0001, 4'b0000));
    tbl.push_back(mk(ins(NOP, ADD, DA), 1, 0, 16'h0001, 0, 4'b0000, 16'h0000, 4'b1010, 4'b0000));
    tbl.push_back(mk(ins(RAMD, OR_, DZ), 0, 7, 16'h0003, 0, 4'b0000, 16'h0003, 4'b0000, 4'b1000));
    tbl.push_back(mk(ins(NOP, OR_, ZB), 0, 7, 16'h0000, 0, 4'b0000, R7, {3'b000, R7_S}, 4'b0000));
    tbl.push_back(mk(ins(NOP, ADD, AQ), 6, 0, 16'h0000, 0, 4'b0000, AQ_SUM, 4'b0001, 4'b0000));

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k], 1'b1, $sformatf("vec%0d", k));
    end

    // Bubbles: a RAMF ADD held with instrValid low must not touch reg[8], Q or Y.
    drive(mk(ins(RAMF, OR_, DZ), 0, 8, 16'h1234, 0, 4'b0000, 16'h1234, 4'b0000, 4'b0000), 1'b1, "bub_set");
    for (int k = 0; k < 3; k++) begin
      drive(mk(ins(RAMF, ADD, DA), 8, 8, 16'h0001, 0, 4'b0000, 16'h0000, 4'b0000, 4'b0000), 1'b0, "bub");
      chk($sformatf("bub%0d.Y_hold", k), {16'd0, Y}, 32'h1234);
    end
    drive(mk(ins(NOP, OR_, ZB), 0, 8, 16'h0000, 0, 4'b0000, 16'h1234, 4'b0000, 4'b0000), 1'b1, "bub_reg");
    drive(mk(ins(NOP, OR_, ZQ), 0, 0, 16'h0000, 0, 4'b0000, Q_U, 4'b0001, 4'b0000), 1'b1, "bub_q");

    // Back-to-back read-after-write accumulation into reg[4].
    drive(mk(ins(RAMF, OR_, DZ), 0, 4, 16'h0000, 0, 4'b0000, 16'h0000, 4'b0010, 4'b0000), 1'b1, "raw_clr");
    for (int k = 0; k < 4; k++) begin
      drive(mk(ins(RAMF, ADD, DA), 4, 4, 16'h0001, 0, 4'b0000, 16'(k + 1), 4'b0000, 4'b0000),
            1'b1, $sformatf("raw%0d", k));
    end

    // Reset asserted mid-cycle with a valid instruction pending.
    instrValid = 1'b1;
    I = ins(RAMF, ADD, DA); addrA = 4'd9; addrB = 4'd9; D = 16'h5555;
    #2 rstBar = 1'b0;
    #1;
    chk("rst_mid.Y", {16'd0, Y}, 32'd0);
    chk("rst_mid.yValid", {31'd0, yValid}, 32'd0);
    chk("rst_mid.flags", {28'd0, cOut, ovf, fZero, fSign}, 32'd0);
    sb.delete();
    @(negedge cp);
    chk("rst_hold.yValid", {31'd0, yValid}, 32'd0);
    rstBar = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(mk(ins(NOP, OR_, ZB), 0, k, 16'h0000, 0, 4'b0000, 16'h0000, 4'b0010, 4'b0000),
            1'b1, $sformatf("rst_rd%0d", k));
    end
    drive(mk(ins(NOP, OR_, ZQ), 0, 0, 16'h0000, 0, 4'b0000, 16'h0000, 4'b0010, 4'b0000), 1'b1, "rst_q");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
